// File: rtl/mem_burst_bridge.sv
// mem_burst_bridge
// Adapts the CPU's single-word memory port to a line memory that moves
// 256-bit lines as four 64-bit beats. A load fetches the whole line and
// returns the addressed word. A store fetches the line, merges the enabled
// bytes, and writes the whole line back. mem_resp pulses once per request.
module mem_burst_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic [31:0] pmem_address,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [63:0] pmem_wdata,
    input  logic [63:0] pmem_rdata,
    input  logic        pmem_resp
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_LINE = 2'd1,
        S_WR_LINE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    // Request captured at acceptance; the CPU inputs are not looked at again.
    logic [26:0]  r_line_addr;
    logic [2:0]   r_word;
    logic [31:0]  r_wdata;
    logic [3:0]   r_be;
    logic         r_wr;

    logic [1:0]   r_cnt;
    logic [255:0] r_line;
    logic [31:0]  r_rdata;

    logic         w_accept;
    logic         w_beat;
    logic         w_last_beat;
    logic [255:0] w_line_nxt;
    logic [31:0]  w_rdata_nxt;
    logic         w_unused;

    // Byte offset within the word is irrelevant for word-sized accesses.
    assign w_unused = &{1'b0, mem_address[1:0]};

    assign w_accept    = (r_state == S_IDLE) && (mem_read || mem_write);
    assign w_beat      = pmem_resp && ((r_state == S_RD_LINE) || (r_state == S_WR_LINE));
    assign w_last_beat = w_beat && (r_cnt == 2'd3);

    // State register; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; a store always takes the read-then-write path.
    always_comb begin
        w_state_nxt = r_state;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        mem_resp    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    w_state_nxt = S_RD_LINE;
                end
            end
            S_RD_LINE: begin
                pmem_read = 1'b1;
                if (w_last_beat) begin
                    w_state_nxt = r_wr ? S_WR_LINE : S_RESP;
                end
            end
            S_WR_LINE: begin
                pmem_write = 1'b1;
                if (w_last_beat) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                mem_resp    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture the request; write wins when both requests are high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_line_addr <= 27'd0;
            r_word      <= 3'd0;
            r_wdata     <= 32'd0;
            r_be        <= 4'd0;
            r_wr        <= 1'b0;
        end else if (w_accept) begin
            r_line_addr <= mem_address[31:5];
            r_word      <= mem_address[4:2];
            r_wdata     <= mem_wdata;
            r_be        <= mem_byte_enable;
            r_wr        <= mem_write;
        end
    end

    // Beat counter; the natural 3->0 wrap on the last read beat readies it for the write burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 2'd0;
        end else if (w_accept) begin
            r_cnt <= 2'd0;
        end else if (w_beat) begin
            r_cnt <= r_cnt + 2'd1;
        end
    end

    // Next line contents: incoming read beat, plus the store merge on the final read beat.
    always_comb begin
        w_line_nxt = r_line;
        if ((r_state == S_RD_LINE) && pmem_resp) begin
            w_line_nxt[{r_cnt, 6'd0} +: 64] = pmem_rdata;
            if ((r_cnt == 2'd3) && r_wr) begin
                if (r_be[0]) w_line_nxt[{r_word, 2'd0, 3'd0} +: 8] = r_wdata[7:0];
                if (r_be[1]) w_line_nxt[{r_word, 2'd1, 3'd0} +: 8] = r_wdata[15:8];
                if (r_be[2]) w_line_nxt[{r_word, 2'd2, 3'd0} +: 8] = r_wdata[23:16];
                if (r_be[3]) w_line_nxt[{r_word, 2'd3, 3'd0} +: 8] = r_wdata[31:24];
            end
        end
        w_rdata_nxt = w_line_nxt[{r_word, 5'd0} +: 32];
    end

    // Line buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_line <= 256'd0;
        end else begin
            r_line <= w_line_nxt;
        end
    end

    // Returned word is latched on entry to RESP and held until the next completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= 32'd0;
        end else if (w_state_nxt == S_RESP) begin
            r_rdata <= w_rdata_nxt;
        end
    end

    assign mem_rdata    = r_rdata;
    assign pmem_address = {r_line_addr, 5'd0};
    assign pmem_wdata   = (r_state == S_WR_LINE) ? r_line[{r_cnt, 6'd0} +: 64] : 64'd0;

endmodule
